lcd_hd44780_responder: RTL and testbench

- Synthesizable HD44780-style responder: the display side of the Spartan-3E character-LCD 4-bit write interface.
- Monitors E/RS/RW/SF_CE/DB[3:0] as driven by the team's LCD control block.
- Checks the power-on init sequence and inter-transfer timing, reassembles nibbles into bytes, and tracks the DDRAM cursor.
- Used in simulation benches and as an on-chip protocol checker.

---
 rtl/lcd_hd44780_responder.sv | 259 +++++++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_hd44780_responder
//  Purpose  : Display-side model / checker of an HD44780 character LCD driven
//             over the Spartan-3E 4-bit write interface. Watches the bus,
//             verifies the power-on init sequence and inter-transfer timing,
//             reassembles nibble pairs into bytes and tracks the DDRAM cursor.
//  Ports    : Clock, Reset (async, active-low)
//             iLCD_Enabled / RegisterSelect / ReadWrite / StrataFlashControl,
//             iLCD_Data[3:0]             - raw LCD bus (DB[7:4])
//             oByte_Valid, oByte[7:0], oByte_IsData - accepted byte
//             oCursor[6:0]               - DDRAM address
//             oInit_Done                 - 4-bit mode established
//             oTiming_Error, oProto_Error - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_hd44780_responder #(
    parameter int unsigned T_POWERUP = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_SHORT   = 2000,
    parameter int unsigned T_NIB     = 50,
    parameter int unsigned T_CLEAR   = 82000,
    parameter int unsigned T_EMIN    = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RegisterSelect,
    input  logic       iLCD_ReadWrite,
    input  logic       iLCD_StrataFlashControl,
    input  logic [3:0] iLCD_Data,
    output logic       oByte_Valid,
    output logic [7:0] oByte,
    output logic       oByte_IsData,
    output logic [6:0] oCursor,
    output logic       oInit_Done,
    output logic       oTiming_Error,
    output logic       oProto_Error
);

    // Gap counter must be able to reach the largest required gap.
    localparam int unsigned M1 = (T_POWERUP > T_INIT1) ? T_POWERUP : T_INIT1;
    localparam int unsigned M2 = (T_INIT2 > T_SHORT) ? T_INIT2 : T_SHORT;
    localparam int unsigned M3 = (T_NIB > T_CLEAR) ? T_NIB : T_CLEAR;
    localparam int unsigned M4 = (M1 > M2) ? M1 : M2;
    localparam int unsigned G_MAX = (M3 > M4) ? M3 : M4;
    localparam int GW = $clog2(G_MAX + 1);
    localparam int WW = $clog2(T_EMIN + 1) + 1;

    localparam logic [GW-1:0] C_POWERUP = GW'(T_POWERUP);
    localparam logic [GW-1:0] C_INIT1   = GW'(T_INIT1);
    localparam logic [GW-1:0] C_INIT2   = GW'(T_INIT2);
    localparam logic [GW-1:0] C_SHORT   = GW'(T_SHORT);
    localparam logic [GW-1:0] C_NIB     = GW'(T_NIB);
    localparam logic [GW-1:0] C_CLEAR   = GW'(T_CLEAR);
    localparam logic [WW-1:0] C_EMIN    = WW'(T_EMIN);

    typedef enum logic [2:0] {
        ST_PWR = 3'd0,
        ST_I1  = 3'd1,
        ST_I2  = 3'd2,
        ST_I3  = 3'd3,
        ST_I4  = 3'd4,
        ST_HI  = 3'd5,
        ST_LO  = 3'd6
    } state_t;

    // Synchronizer vector: {E, RS, RW, SF_CE, DB[3:0]}
    logic [7:0]    sync1_q, sync2_q;
    logic          e_prev_q;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [GW-1:0] req_q, req_d;
    logic [WW-1:0] wid_q, wid_d;
    logic [3:0]    hi_q, hi_d;
    logic          hirs_q, hirs_d;
    logic          pend_q, pend_d;
    logic [7:0]    pbyte_q, pbyte_d;
    logic          prs_q, prs_d;
    logic          valid_q, valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          isdata_q, isdata_d;
    logic [6:0]    cursor_q, cursor_d;
    logic          init_q, init_d;
    logic          terr_q, terr_d;
    logic          perr_q, perr_d;

    logic       w_e, w_rs, w_rw, w_sf, w_rise, w_fall;
    logic [3:0] w_db;

    assign w_e    = sync2_q[7];
    assign w_rs   = sync2_q[6];
    assign w_rw   = sync2_q[5];
    assign w_sf   = sync2_q[4];
    assign w_db   = sync2_q[3:0];
    assign w_rise = w_e & ~e_prev_q;
    assign w_fall = ~w_e & e_prev_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            e_prev_q <= 1'b0;
            state_q  <= ST_PWR;
            gap_q    <= '0;
            req_q    <= C_POWERUP;
            wid_q    <= '0;
            hi_q     <= '0;
            hirs_q   <= 1'b0;
            pend_q   <= 1'b0;
            pbyte_q  <= '0;
            prs_q    <= 1'b0;
            valid_q  <= 1'b0;
            byte_q   <= '0;
            isdata_q <= 1'b0;
            cursor_q <= '0;
            init_q   <= 1'b0;
            terr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            sync1_q  <= {iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite,
                         iLCD_StrataFlashControl, iLCD_Data};
            sync2_q  <= sync1_q;
            e_prev_q <= w_e;
            state_q  <= state_d;
            gap_q    <= gap_d;
            req_q    <= req_d;
            wid_q    <= wid_d;
            hi_q     <= hi_d;
            hirs_q   <= hirs_d;
            pend_q   <= pend_d;
            pbyte_q  <= pbyte_d;
            prs_q    <= prs_d;
            valid_q  <= valid_d;
            byte_q   <= byte_d;
            isdata_q <= isdata_d;
            cursor_q <= cursor_d;
            init_q   <= init_d;
            terr_q   <= terr_d;
            perr_q   <= perr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = (gap_q == '1) ? gap_q : gap_q + 1'b1;
        req_d    = req_q;
        wid_d    = wid_q;
        hi_d     = hi_q;
        hirs_d   = hirs_q;
        pend_d   = 1'b0;
        pbyte_d  = pbyte_q;
        prs_d    = prs_q;
        valid_d  = 1'b0;
        byte_d   = byte_q;
        isdata_d = isdata_q;
        cursor_d = cursor_q;
        init_d   = init_q;
        terr_d   = terr_q;
        perr_d   = perr_q;

        // E-high width: equals the number of cycles E was seen high at the fall.
        if (w_rise) begin
            wid_d = {{(WW-1){1'b0}}, 1'b1};
        end else if (w_e && (wid_q != '1)) begin
            wid_d = wid_q + 1'b1;
        end

        if (w_rise) begin
            if (gap_q < req_q) begin
                terr_d = 1'b1;
            end
            if (state_q == ST_PWR) begin
                state_d = ST_I1;
            end
        end

        if (w_fall) begin
            if (wid_q < C_EMIN) begin
                terr_d = 1'b1;
            end
            if (w_rw || !w_sf) begin
                perr_d = 1'b1;
            end else begin
                // Fall takes priority over saturation of the gap counter.
                gap_d = '0;
                case (state_q)
                    ST_I1: begin
                        if (w_db == 4'h3) begin state_d = ST_I2; req_d = C_INIT1; end
                        else perr_d = 1'b1;
                    end
                    ST_I2: begin
                        if (w_db == 4'h3) begin state_d = ST_I3; req_d = C_INIT2; end
                        else perr_d = 1'b1;
                    end
                    ST_I3: begin
                        if (w_db == 4'h3) begin state_d = ST_I4; req_d = C_SHORT; end
                        else perr_d = 1'b1;
                    end
                    ST_I4: begin
                        if (w_db == 4'h2) begin
                            state_d = ST_HI;
                            req_d   = C_SHORT;
                            init_d  = 1'b1;
                        end else begin
                            perr_d = 1'b1;
                        end
                    end
                    ST_HI: begin
                        hi_d    = w_db;
                        hirs_d  = w_rs;
                        req_d   = C_NIB;
                        state_d = ST_LO;
                    end
                    ST_LO: begin
                        if (w_rs != hirs_q) begin
                            perr_d = 1'b1;
                        end
                        pbyte_d = {hi_q, w_db};
                        prs_d   = hirs_q;
                        pend_d  = 1'b1;
                        state_d = ST_HI;
                    end
                    default: ;
                endcase
            end
        end

        // Publish the byte one cycle after the low-nibble fall was processed.
        if (pend_q) begin
            valid_d  = 1'b1;
            byte_d   = pbyte_q;
            isdata_d = prs_q;
            req_d    = C_SHORT;
            if (prs_q) begin
                if (cursor_q == 7'h27)      cursor_d = 7'h40;
                else if (cursor_q == 7'h67) cursor_d = 7'h00;
                else                        cursor_d = cursor_q + 7'd1;
            end else if (pbyte_q[7:2] == 6'b0 && pbyte_q[1:0] != 2'b00) begin
                cursor_d = 7'h00;       // Clear (0x01) or Home (0x02/0x03)
                req_d    = C_CLEAR;
            end else if (pbyte_q[7]) begin
                cursor_d = pbyte_q[6:0];
            end
        end
    end

    assign oByte_Valid   = valid_q;
    assign oByte         = byte_q;
    assign oByte_IsData  = isdata_q;
    assign oCursor       = cursor_q;
    assign oInit_Done    = init_q;
    assign oTiming_Error = terr_q;
    assign oProto_Error  = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_hd44780_responder
//  Purpose  : Directed bench for lcd_hd44780_responder with small timing
//             parameters; expected bytes go through a scoreboard queue that a
//             separate monitor drains whenever oByte_Valid is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_responder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       e_i = 1'b0, rs_i = 1'b0, rw_i = 1'b0, sf_i = 1'b1;
    logic [3:0] db_i = 4'h0;
    logic       oByte_Valid, oByte_IsData, oInit_Done, oTiming_Error, oProto_Error;
    logic [7:0] oByte;
    logic [6:0] oCursor;

    lcd_hd44780_responder #(
        .T_POWERUP(100), .T_INIT1(40), .T_INIT2(20), .T_SHORT(10),
        .T_NIB(4), .T_CLEAR(30), .T_EMIN(3)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iLCD_Enabled            (e_i),
        .iLCD_RegisterSelect     (rs_i),
        .iLCD_ReadWrite          (rw_i),
        .iLCD_StrataFlashControl (sf_i),
        .iLCD_Data               (db_i),
        .oByte_Valid             (oByte_Valid),
        .oByte                   (oByte),
        .oByte_IsData            (oByte_IsData),
        .oCursor                 (oCursor),
        .oInit_Done              (oInit_Done),
        .oTiming_Error           (oTiming_Error),
        .oProto_Error            (oProto_Error)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic       d;
        logic [6:0] cur;
        int         ecyc;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a byte is presented.
    logic prev_v = 1'b0;
    initial begin
        exp_t ex;
        forever begin
            @(negedge Clock);
            if (oByte_Valid) begin
                chk("valid_one_cycle", {31'b0, prev_v}, 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", oByte);
                end else begin
                    ex = sb_q.pop_front();
                    chk("byte",     {24'b0, oByte},        {24'b0, ex.b});
                    chk("is_data",  {31'b0, oByte_IsData}, {31'b0, ex.d});
                    chk("cursor",   {25'b0, oCursor},      {25'b0, ex.cur});
                    chk("latency",  cyc,                   ex.ecyc);
                end
            end
            prev_v = oByte_Valid;
        end
    end

    // One E strobe; data held until the next strobe starts.
    task automatic nib(input logic r, input logic w, input logic s, input logic [3:0] d,
                       input int width, input int gap, input logic push,
                       input logic [7:0] pb, input logic pd, input logic [6:0] pc);
        exp_t ex;
        @(posedge Clock); #1;
        rs_i = r; rw_i = w; sf_i = s; db_i = d; e_i = 1'b1;
        repeat (width) @(posedge Clock);
        #1;
        if (push) begin
            ex.b = pb; ex.d = pd; ex.cur = pc; ex.ecyc = cyc + 4;
            sb_q.push_back(ex);
        end
        e_i = 1'b0;
        repeat (gap) @(posedge Clock);
    endtask

    task automatic sb(input logic r, input logic [7:0] b, input int gap, input logic [6:0] cur);
        nib(r, 1'b0, 1'b1, b[7:4], 6, 8, 1'b0, 8'h00, 1'b0, 7'h00);
        nib(r, 1'b0, 1'b1, b[3:0], 6, gap, 1'b1, b, r, cur);
    endtask

    task automatic do_init();
        repeat (120) @(posedge Clock);
        nib(1'b0, 1'b0, 1'b1, 4'h3, 6, 50, 1'b0, 8'h00, 1'b0, 7'h00);
        nib(1'b0, 1'b0, 1'b1, 4'h3, 6, 30, 1'b0, 8'h00, 1'b0, 7'h00);
        nib(1'b0, 1'b0, 1'b1, 4'h3, 6, 15, 1'b0, 8'h00, 1'b0, 7'h00);
        nib(1'b0, 1'b0, 1'b1, 4'h2, 6, 15, 1'b0, 8'h00, 1'b0, 7'h00);
    endtask

    task automatic do_reset(input string name);
        @(posedge Clock); #1;
        Reset = 1'b0;
        e_i = 1'b0; rs_i = 1'b0; rw_i = 1'b0; sf_i = 1'b1; db_i = 4'h0;
        @(negedge Clock);
        chk(name, {13'b0, oByte_Valid, oByte, oByte_IsData, oCursor, oInit_Done,
                   oTiming_Error, oProto_Error}, 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b1;
    endtask

    task automatic flags(input string name, input logic init, input logic terr, input logic perr);
        @(negedge Clock);
        chk({name, "_init"}, {31'b0, oInit_Done},    {31'b0, init});
        chk({name, "_terr"}, {31'b0, oTiming_Error}, {31'b0, terr});
        chk({name, "_perr"}, {31'b0, oProto_Error},  {31'b0, perr});
    endtask

    initial begin
        // Power-on reset, then legal init and normal byte traffic.
        do_reset("reset_state");
        do_init();
        flags("after_init", 1'b1, 1'b0, 1'b0);
        sb(1'b0, 8'h80, 15, 7'h00);
        sb(1'b1, 8'h48, 15, 7'h01);
        sb(1'b1, 8'h69, 15, 7'h02);
        sb(1'b0, 8'hA7, 15, 7'h27);
        sb(1'b1, 8'h41, 15, 7'h40);   // wrap 0x27 -> 0x40
        sb(1'b0, 8'hE7, 15, 7'h67);
        sb(1'b1, 8'h42, 15, 7'h00);   // wrap 0x67 -> 0x00
        flags("after_bytes", 1'b1, 1'b0, 1'b0);
        // Clear followed too soon by the next strobe.
        sb(1'b0, 8'h01, 20, 7'h00);
        sb(1'b0, 8'h80, 15, 7'h00);
        flags("clear_gap", 1'b1, 1'b1, 1'b0);

        // Runt E pulse.
        do_reset("reset_2");
        do_init();
        nib(1'b0, 1'b0, 1'b1, 4'h4, 2, 8, 1'b0, 8'h00, 1'b0, 7'h00);
        nib(1'b0, 1'b0, 1'b1, 4'h8, 6, 15, 1'b1, 8'h48, 1'b0, 7'h00);
        flags("short_e", 1'b1, 1'b1, 1'b0);

        // Wrong init nibble at I2.
        do_reset("reset_3");
        repeat (120) @(posedge Clock);
        nib(1'b0, 1'b0, 1'b1, 4'h3, 6, 50, 1'b0, 8'h00, 1'b0, 7'h00);
        nib(1'b0, 1'b0, 1'b1, 4'h5, 6, 30, 1'b0, 8'h00, 1'b0, 7'h00);
        flags("bad_init", 1'b0, 1'b0, 1'b1);

        // SF_CE low strobe is ignored; the next byte still decodes cleanly.
        do_reset("reset_4");
        do_init();
        nib(1'b0, 1'b0, 1'b0, 4'hF, 6, 15, 1'b0, 8'h00, 1'b0, 7'h00);
        flags("sf_ce_low", 1'b1, 1'b0, 1'b1);
        sb(1'b1, 8'h41, 15, 7'h01);

        // Reset between the two nibbles of a byte discards the partial byte.
        do_reset("reset_5");
        do_init();
        nib(1'b1, 1'b0, 1'b1, 4'h7, 6, 8, 1'b0, 8'h00, 1'b0, 7'h00);
        do_reset("reset_mid_byte");
        do_init();
        sb(1'b1, 8'h48, 15, 7'h01);
        flags("after_mid_reset", 1'b1, 1'b0, 1'b0);

        repeat (20) @(posedge Clock);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
